// File: rtl/systolic_sequencer.sv
// rtl/systolic_sequencer.sv - sequences one output-stationary tile on the systolic array
// Fetches operand vectors, skews them onto the array edges, then captures the drained result columns.

module systolic_skew_lane #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0]     dq [DEPTH];
  logic [DEPTH-1:0] vq;

  always_ff @(posedge clk) begin
    if (rst) begin
      vq <= '0;
      for (int i = 0; i < DEPTH; i++) dq[i] <= '0;
    end else begin
      vq[0] <= vld;
      dq[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        vq[i] <= vq[i-1];
        dq[i] <= dq[i-1];
      end
    end
  end

  assign dout = vq[DEPTH-1] ? dq[DEPTH-1] : '0;
endmodule

module systolic_sequencer #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 8,
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int ADDR_W    = 8,
  parameter int K_W       = 8,
  parameter int MULT_LAT  = 3,
  parameter int ACC_LAT   = 1,
  parameter int DRAIN_LAT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [K_W-1:0]            k_len,
  input  logic [ADDR_W-1:0]         base_a,
  input  logic [ADDR_W-1:0]         base_b,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      a_rd_en,
  output logic [ADDR_W-1:0]         a_rd_addr,
  input  logic [IN_WIDTH*ROWS-1:0]  a_rd_data,
  output logic                      b_rd_en,
  output logic [ADDR_W-1:0]         b_rd_addr,
  input  logic [IN_WIDTH*COLS-1:0]  b_rd_data,
  output logic                      arr_rst_acc,
  output logic                      arr_stream_out,
  output logic [IN_WIDTH*ROWS-1:0]  arr_row_data,
  output logic [IN_WIDTH*COLS-1:0]  arr_col_data,
  input  logic [OUT_WIDTH*ROWS-1:0] arr_row_data_out,
  output logic                      out_valid,
  output logic [$clog2(COLS)-1:0]   out_col,
  output logic [OUT_WIDTH*ROWS-1:0] out_data
);
  localparam int FLUSH_CYC = ROWS + COLS - 1 + MULT_LAT + ACC_LAT;
  localparam int DRAIN_CYC = DRAIN_LAT + COLS;
  localparam int PH_MAX    = (FLUSH_CYC > DRAIN_CYC) ? FLUSH_CYC : DRAIN_CYC;
  localparam int PH_W      = $clog2(PH_MAX + 1);
  localparam int COL_W     = $clog2(COLS);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [K_W-1:0]    k_q, k_len_q;
  logic [ADDR_W-1:0] base_a_q, base_b_q;
  logic [PH_W-1:0]   ph_q;
  logic              rd_vld_q;
  logic              accept, feed_last, flush_last, drain_last, cap;

  assign accept     = (state_q == S_IDLE) && start && (k_len != '0);
  assign feed_last  = (k_q == k_len_q - K_W'(1));
  assign flush_last = (ph_q == PH_W'(FLUSH_CYC - 1));
  assign drain_last = (ph_q == PH_W'(DRAIN_CYC));
  // Beats arrive DRAIN_LAT cycles after the stream_out pulse, which is issued at ph_q==0.
  assign cap = (state_q == S_DRAIN) && (ph_q >= PH_W'(DRAIN_LAT)) && (ph_q < PH_W'(DRAIN_CYC));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    busy           = 1'b1;
    done           = 1'b0;
    arr_rst_acc    = 1'b0;
    arr_stream_out = 1'b0;
    a_rd_en        = 1'b0;
    b_rd_en        = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (accept) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        arr_rst_acc = 1'b1;
        state_d     = S_FEED;
      end
      S_FEED: begin
        a_rd_en = 1'b1;
        b_rd_en = 1'b1;
        if (feed_last) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (flush_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        arr_stream_out = (ph_q == '0);
        if (drain_last) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign a_rd_addr = a_rd_en ? base_a_q + ADDR_W'(k_q) : '0;
  assign b_rd_addr = b_rd_en ? base_b_q + ADDR_W'(k_q) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q       <= '0;
      k_len_q   <= '0;
      base_a_q  <= '0;
      base_b_q  <= '0;
      ph_q      <= '0;
      rd_vld_q  <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_col   <= '0;
      out_data  <= '0;
    end else begin
      err       <= (state_q == S_IDLE) && start && (k_len == '0);
      rd_vld_q  <= a_rd_en;
      out_valid <= cap;
      out_col   <= cap ? COL_W'(ph_q - PH_W'(DRAIN_LAT)) : '0;
      out_data  <= cap ? arr_row_data_out : '0;
      k_q       <= (state_q == S_FEED) ? k_q + K_W'(1) : '0;
      ph_q      <= ((state_q == S_FLUSH || state_q == S_DRAIN) && state_d == state_q) ?
                   ph_q + PH_W'(1) : '0;
      if (accept) begin
        k_len_q  <= k_len;
        base_a_q <= base_a;
        base_b_q <= base_b;
      end
    end
  end

  // Lane 0 passes straight through once read data is valid; lane i waits i extra cycles.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    if (r == 0) begin : g_lane0
      assign arr_row_data[IN_WIDTH-1:0] = rd_vld_q ? a_rd_data[IN_WIDTH-1:0] : '0;
    end else begin : g_lane
      systolic_skew_lane #(.W(IN_WIDTH), .DEPTH(r)) u_lane (
        .clk  (clk),
        .rst  (rst),
        .vld  (rd_vld_q),
        .din  (a_rd_data[r*IN_WIDTH +: IN_WIDTH]),
        .dout (arr_row_data[r*IN_WIDTH +: IN_WIDTH])
      );
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    if (c == 0) begin : g_lane0
      assign arr_col_data[IN_WIDTH-1:0] = rd_vld_q ? b_rd_data[IN_WIDTH-1:0] : '0;
    end else begin : g_lane
      systolic_skew_lane #(.W(IN_WIDTH), .DEPTH(c)) u_lane (
        .clk  (clk),
        .rst  (rst),
        .vld  (rd_vld_q),
        .din  (b_rd_data[c*IN_WIDTH +: IN_WIDTH]),
        .dout (arr_col_data[c*IN_WIDTH +: IN_WIDTH])
      );
    end
  end
endmodule

// File: tb/tb_systolic_sequencer.sv
// tb/tb_systolic_sequencer.sv - self-checking bench for systolic_sequencer
// Buffers and array drain are modelled here; expected schedules come from cycle counts since accept.

module tb_systolic_sequencer;
  localparam int IN_WIDTH  = 8;
  localparam int OUT_WIDTH = 8;
  localparam int ROWS      = 4;
  localparam int COLS      = 4;
  localparam int ADDR_W    = 8;
  localparam int K_W       = 8;
  localparam int MULT_LAT  = 3;
  localparam int ACC_LAT   = 1;
  localparam int DRAIN_LAT = 4;
  localparam int FLUSH_CYC = ROWS + COLS - 1 + MULT_LAT + ACC_LAT;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int CW        = $clog2(COLS);

  logic clk = 1'b0;
  logic rst, start, busy, done, err;
  logic [K_W-1:0] k_len;
  logic [ADDR_W-1:0] base_a, base_b, a_rd_addr, b_rd_addr;
  logic a_rd_en, b_rd_en, arr_rst_acc, arr_stream_out, out_valid;
  logic [IN_WIDTH*ROWS-1:0] a_rd_data, arr_row_data;
  logic [IN_WIDTH*COLS-1:0] b_rd_data, arr_col_data;
  logic [OUT_WIDTH*ROWS-1:0] arr_row_data_out, out_data;
  logic [CW-1:0] out_col;

  logic [IN_WIDTH*ROWS-1:0] mem_a [DEPTH];
  logic [IN_WIDTH*COLS-1:0] mem_b [DEPTH];
  int c_exp [ROWS][COLS];
  int drain_t = 1000;
  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  systolic_sequencer #(
    .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W),
    .K_W(K_W), .MULT_LAT(MULT_LAT), .ACC_LAT(ACC_LAT), .DRAIN_LAT(DRAIN_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .base_a(base_a), .base_b(base_b),
    .busy(busy), .done(done), .err(err),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .arr_rst_acc(arr_rst_acc), .arr_stream_out(arr_stream_out),
    .arr_row_data(arr_row_data), .arr_col_data(arr_col_data),
    .arr_row_data_out(arr_row_data_out),
    .out_valid(out_valid), .out_col(out_col), .out_data(out_data)
  );

  // Operand buffers: one-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    a_rd_data <= a_rd_en ? mem_a[a_rd_addr] : $urandom;
    b_rd_data <= b_rd_en ? mem_b[b_rd_addr] : $urandom;
  end

  function automatic logic [OUT_WIDTH*ROWS-1:0] col_vec(input int j);
    logic [OUT_WIDTH*ROWS-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++) v[r*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(c_exp[r][j]);
    return v;
  endfunction

  // Array drain: result column j appears DRAIN_LAT+j cycles after stream_out; garbage otherwise.
  always @(negedge clk) begin
    if (arr_stream_out) drain_t = 0;
    else if (drain_t < 1000) drain_t++;
    if (drain_t >= DRAIN_LAT && drain_t < DRAIN_LAT + COLS) arr_row_data_out = col_vec(drain_t - DRAIN_LAT);
    else arr_row_data_out = $urandom;
  end

  function automatic logic [7:0] obs_ctrl();
    return {busy, done, err, arr_rst_acc, arr_stream_out, a_rd_en, b_rd_en, out_valid};
  endfunction

  function automatic logic [121:0] obs_all();
    return {obs_ctrl(), a_rd_addr, b_rd_addr, arr_row_data, arr_col_data, out_col, out_data};
  endfunction

  function automatic logic [IN_WIDTH*(ROWS+COLS)-1:0] exp_arr(input int n, input int kl, input int ba, input int bb);
    logic [IN_WIDTH*ROWS-1:0] rv;
    logic [IN_WIDTH*COLS-1:0] cv;
    int k;
    rv = '0;
    cv = '0;
    for (int r = 0; r < ROWS; r++) begin
      k = n - 3 - r;
      if (k >= 0 && k < kl) rv[r*IN_WIDTH +: IN_WIDTH] = mem_a[(ba + k) % DEPTH][r*IN_WIDTH +: IN_WIDTH];
    end
    for (int c = 0; c < COLS; c++) begin
      k = n - 3 - c;
      if (k >= 0 && k < kl) cv[c*IN_WIDTH +: IN_WIDTH] = mem_b[(bb + k) % DEPTH][c*IN_WIDTH +: IN_WIDTH];
    end
    return {rv, cv};
  endfunction

  task automatic compute_c(input int kl, input int ba, input int bb);
    int s;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        s = 0;
        for (int k = 0; k < kl; k++)
          s += int'(mem_a[(ba + k) % DEPTH][r*IN_WIDTH +: IN_WIDTH]) *
               int'(mem_b[(bb + k) % DEPTH][c*IN_WIDTH +: IN_WIDTH]);
        c_exp[r][c] = s;
      end
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = $urandom;
    end
  endtask

  // Called at a negedge; the start is accepted at the following posedge (cycle n=1 is CLEAR).
  task automatic run_tile(input int kl, input int ba, input int bb, input bit hold);
    int n_d, n_done, j;
    bit feed, ov;
    logic [7:0] e_ctrl;
    logic [2*ADDR_W-1:0] e_addr;
    compute_c(kl, ba, bb);
    n_d    = kl + 2 + FLUSH_CYC;
    n_done = n_d + DRAIN_LAT + COLS + 1;
    start  = 1'b1;
    k_len  = K_W'(kl);
    base_a = ADDR_W'(ba);
    base_b = ADDR_W'(bb);
    for (int n = 1; n <= n_done + 1; n++) begin
      @(negedge clk);
      feed   = (n >= 2) && (n <= kl + 1);
      ov     = (n >= n_d + DRAIN_LAT + 1) && (n <= n_d + DRAIN_LAT + COLS);
      j      = n - (n_d + DRAIN_LAT + 1);
      e_ctrl = {n <= n_done, n == n_done, 1'b0, n == 1, n == n_d, feed, feed, ov};
      e_addr = feed ? {ADDR_W'(ba + n - 2), ADDR_W'(bb + n - 2)} : '0;
      ncmp++;
      if (obs_ctrl() !== e_ctrl) begin
        nerr++;
        $display("FAIL ctrl k=%0d n=%0d got %b want %b (busy,done,err,rst_acc,stream,a_en,b_en,valid)", kl, n, obs_ctrl(), e_ctrl);
      end
      ncmp++;
      if ({a_rd_addr, b_rd_addr} !== e_addr) begin
        nerr++;
        $display("FAIL addr k=%0d n=%0d got %h want %h", kl, n, {a_rd_addr, b_rd_addr}, e_addr);
      end
      ncmp++;
      if ({arr_row_data, arr_col_data} !== exp_arr(n, kl, ba, bb)) begin
        nerr++;
        $display("FAIL skew k=%0d n=%0d got %h want %h", kl, n, {arr_row_data, arr_col_data}, exp_arr(n, kl, ba, bb));
      end
      if (ov) begin
        ncmp++;
        if ({out_col, out_data} !== {CW'(j), col_vec(j)}) begin
          nerr++;
          $display("FAIL beat k=%0d n=%0d got col %0d data %h want col %0d data %h", kl, n, out_col, out_data, j, col_vec(j));
        end
      end
      if (!hold) start = 1'b0;
      else begin
        k_len  = K_W'($urandom);
        base_a = ADDR_W'($urandom);
        base_b = ADDR_W'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    k_len = '0;
    base_a = '0;
    base_b = '0;
    repeat (3) @(negedge clk);
    ncmp++;
    if (obs_all() !== '0) begin
      nerr++;
      $display("FAIL reset got %h want 0", obs_all());
    end
    rst = 1'b0;
  endtask

  task automatic test_identity();
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < ROWS; r++) mem_a[8'h10 + k][r*IN_WIDTH +: IN_WIDTH] = (r == k) ? 8'd1 : 8'd0;
      for (int c = 0; c < COLS; c++) mem_b[8'h40 + k][c*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'(4 * k + c + 1);
    end
    run_tile(4, 8'h10, 8'h40, 1'b0);
  endtask

  task automatic test_skew();
    mem_a[8'h20] = {8'd4, 8'd3, 8'd2, 8'd1};
    mem_b[8'h30] = {8'd8, 8'd7, 8'd6, 8'd5};
    run_tile(1, 8'h20, 8'h30, 1'b0);
  endtask

  task automatic test_kzero();
    start = 1'b1;
    k_len = '0;
    base_a = 8'h55;
    base_b = 8'hAA;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      start = 1'b0;
      ncmp++;
      if (obs_all() !== {(n == 1) ? 8'b0010_0000 : 8'b0, 114'b0}) begin
        nerr++;
        $display("FAIL kzero n=%0d got %h want err=%0d only", n, obs_all(), n == 1);
      end
    end
  endtask

  task automatic test_wrap();
    fill_random();
    run_tile(4, 8'hFE, 8'hFD, 1'b0);
  endtask

  task automatic test_back_to_back();
    fill_random();
    run_tile(3 + int'($urandom_range(0, 5)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b1);
    run_tile(2 + int'($urandom_range(0, 5)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0);
  endtask

  task automatic test_reset_mid();
    fill_random();
    start = 1'b1;
    k_len = 8'd10;
    base_a = 8'h00;
    base_b = 8'h80;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    ncmp++;
    if (obs_all() !== '0) begin
      nerr++;
      $display("FAIL reset_mid got %h want 0", obs_all());
    end
    rst = 1'b0;
    @(negedge clk);
    run_tile(6, 8'h11, 8'h22, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      fill_random();
      run_tile(int'($urandom_range(1, 24)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0);
    end
    fill_random();
    run_tile(255, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_skew();
    test_kzero();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
